// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W         = 5;
  localparam int unsigned CNT_W_DEFAULT     = 32;
  localparam int unsigned DRAIN_MAX_DEFAULT = 64;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    TRAP_WAIT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'd0,
    PC_BR      = 2'd1,
    PC_TRAP    = 2'd2,
    PC_REFETCH = 2'd3
  } pc_sel_e;

  // One bit per pipeline register, IF first.
  typedef struct packed {
    logic if_s;
    logic id_s;
    logic exe_s;
    logic mem_s;
  } stage_vec_t;

  localparam stage_vec_t STAGES_NONE = '{if_s: 1'b0, id_s: 1'b0, exe_s: 1'b0, mem_s: 1'b0};
  localparam stage_vec_t STAGES_ALL  = '{if_s: 1'b1, id_s: 1'b1, exe_s: 1'b1, mem_s: 1'b1};

  // A holding stage forces every earlier stage to hold as well.
  function automatic stage_vec_t chain_hold(input stage_vec_t h);
    stage_vec_t r;
    r.mem_s = h.mem_s;
    r.exe_s = h.exe_s | r.mem_s;
    r.id_s  = h.id_s  | r.exe_s;
    r.if_s  = h.if_s  | r.id_s;
    return r;
  endfunction

  function automatic logic pipe_empty(input logic exe_v, input logic mem_v,
                                      input logic wb_v, input logic mem_bsy);
    return !exe_v && !mem_v && !wb_v && !mem_bsy;
  endfunction

endpackage

// File: rtl/hz_loaduse_det.sv
// Load-use hazard comparator: a load in EXE feeding a source operand read in ID.
module hz_loaduse_det
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                 id_valid_i,
  input  logic                 id_rs1_en_i,
  input  logic                 id_rs2_en_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 exe_valid_i,
  input  logic                 exe_rd_en_i,
  input  logic                 exe_mem_read_i,
  input  logic [REG_IDX_W-1:0] exe_rd_i,
  output logic                 lu_o
);

  logic load_writes;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer.
  assign load_writes = exe_valid_i && exe_mem_read_i && exe_rd_en_i &&
                       (exe_rd_i != REG_IDX_W'(0));
  assign rs1_hit     = id_rs1_en_i && (id_rs1_i == exe_rd_i);
  assign rs2_hit     = id_rs2_en_i && (id_rs2_i == exe_rd_i);
  assign lu_o        = id_valid_i && load_writes && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; owns fence.i drain
// and trap-wait sequencing plus the stall-cycle counter and drain watchdog.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_rs1_en,
  input  logic                 id_rs2_en,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_fence_i,
  input  logic                 exe_valid,
  input  logic                 exe_rd_en,
  input  logic [REG_IDX_W-1:0] exe_rd,
  input  logic                 exe_mem_read,
  input  logic                 exe_busy,
  input  logic                 exe_fw_valid,
  input  logic                 exe_redirect,
  input  logic                 mem_valid,
  input  logic                 wb_valid,
  input  logic                 mem_busy,
  input  logic                 if_busy,
  input  logic                 trap_req,
  output logic                 if_ready,
  output logic                 id_ready,
  output logic                 exe_ready,
  output logic                 mem_ready,
  output logic                 if_flush,
  output logic                 id_flush,
  output logic                 exe_flush,
  output logic                 mem_flush,
  output logic [1:0]           pc_sel,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 timeout_err
);

  localparam int unsigned DC_W = $clog2(DRAIN_MAX + 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d, drain_cnt_inc;
  logic             timeout_q, timeout_d;

  stage_vec_t hold_raw;
  stage_vec_t hold;
  stage_vec_t flush;
  pc_sel_e    pc_sel_d;
  logic       lu;
  logic       drained;

  hz_loaduse_det u_lu (
    .id_valid_i     (id_valid),
    .id_rs1_en_i    (id_rs1_en),
    .id_rs2_en_i    (id_rs2_en),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .exe_valid_i    (exe_valid),
    .exe_rd_en_i    (exe_rd_en),
    .exe_mem_read_i (exe_mem_read),
    .exe_rd_i       (exe_rd),
    .lu_o           (lu)
  );

  assign drained = pipe_empty(exe_valid, mem_valid, wb_valid, mem_busy);

  // Next-state and per-stage hold/flush decision, highest priority first.
  always_comb begin
    state_d  = state_q;
    hold_raw = STAGES_NONE;
    flush    = STAGES_NONE;
    pc_sel_d = PC_SEQ;

    if (rst) begin
      flush   = STAGES_ALL;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (trap_req && mem_busy) begin
            hold_raw.mem_s = 1'b1;
            state_d        = TRAP_WAIT;
          end else if (trap_req) begin
            flush    = STAGES_ALL;
            pc_sel_d = PC_TRAP;
          end else if (mem_busy) begin
            hold_raw.mem_s = 1'b1;
          end else if (exe_busy || !exe_fw_valid) begin
            hold_raw.exe_s = 1'b1;
            flush.mem_s    = 1'b1;
          end else if (exe_redirect) begin
            flush.if_s = 1'b1;
            flush.id_s = 1'b1;
            pc_sel_d   = PC_BR;
          end else if (lu) begin
            hold_raw.id_s = 1'b1;
            flush.exe_s   = 1'b1;
          end else if (id_valid && id_fence_i) begin
            hold_raw.id_s = 1'b1;
            flush.exe_s   = 1'b1;
            state_d       = DRAIN;
          end else if (if_busy) begin
            hold_raw.if_s = 1'b1;
            flush.id_s    = 1'b1;
          end
        end

        DRAIN: begin
          if (trap_req && mem_busy) begin
            hold_raw.mem_s = 1'b1;
            state_d        = TRAP_WAIT;
          end else if (trap_req) begin
            flush    = STAGES_ALL;
            pc_sel_d = PC_TRAP;
            state_d  = RUN;
          end else if (drained) begin
            // fence.i leaves ID into EXE while the front end refetches.
            flush.if_s = 1'b1;
            flush.id_s = 1'b1;
            pc_sel_d   = PC_REFETCH;
            state_d    = RUN;
          end else begin
            hold_raw.id_s = 1'b1;
            flush.exe_s   = 1'b1;
          end
        end

        TRAP_WAIT: begin
          if (!mem_busy) begin
            flush    = STAGES_ALL;
            pc_sel_d = PC_TRAP;
            state_d  = RUN;
          end else begin
            hold_raw.mem_s = 1'b1;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  // A flushed stage never reports ready.
  assign hold      = chain_hold(hold_raw);
  assign if_ready  = !hold.if_s  && !flush.if_s;
  assign id_ready  = !hold.id_s  && !flush.id_s;
  assign exe_ready = !hold.exe_s && !flush.exe_s;
  assign mem_ready = !hold.mem_s && !flush.mem_s;
  assign if_flush  = flush.if_s;
  assign id_flush  = flush.id_s;
  assign exe_flush = flush.exe_s;
  assign mem_flush = flush.mem_s;
  assign pc_sel    = 2'(pc_sel_d);

  // Counter and watchdog next-state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!if_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    drain_cnt_inc = drain_cnt_q;
    if ((state_q != RUN) && (drain_cnt_q != DC_W'(DRAIN_MAX))) begin
      drain_cnt_inc = drain_cnt_q + DC_W'(1);
    end
    drain_cnt_d = (state_d == RUN) ? DC_W'(0) : drain_cnt_inc;

    timeout_d = timeout_q ||
                ((state_q != RUN) && (drain_cnt_inc == DC_W'(DRAIN_MAX)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_en, id_rs2_en, id_fence_i;
  logic [4:0]  id_rs1, id_rs2, exe_rd;
  logic        exe_valid, exe_rd_en, exe_mem_read, exe_busy, exe_fw_valid, exe_redirect;
  logic        mem_valid, wb_valid, mem_busy, if_busy, trap_req;
  logic        if_ready, id_ready, exe_ready, mem_ready;
  logic        if_flush, id_flush, exe_flush, mem_flush;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cnt;
  logic        timeout_err;

  logic [7:0]  ctl;
  int          checks = 0;
  int          errors = 0;
  int          exp_stall = 0;

  assign ctl = {if_ready, id_ready, exe_ready, mem_ready, if_flush, id_flush, exe_flush, mem_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32), .DRAIN_MAX(64)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_fence_i(id_fence_i),
    .exe_valid(exe_valid), .exe_rd_en(exe_rd_en), .exe_rd(exe_rd),
    .exe_mem_read(exe_mem_read), .exe_busy(exe_busy), .exe_fw_valid(exe_fw_valid),
    .exe_redirect(exe_redirect), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .mem_busy(mem_busy), .if_busy(if_busy), .trap_req(trap_req),
    .if_ready(if_ready), .id_ready(id_ready), .exe_ready(exe_ready), .mem_ready(mem_ready),
    .if_flush(if_flush), .id_flush(id_flush), .exe_flush(exe_flush), .mem_flush(mem_flush),
    .pc_sel(pc_sel), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
  );

  task automatic idle();
    id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_fence_i = 0;
    id_rs1 = 0; id_rs2 = 0; exe_rd = 0;
    exe_valid = 0; exe_rd_en = 0; exe_mem_read = 0; exe_busy = 0;
    exe_fw_valid = 1; exe_redirect = 0;
    mem_valid = 0; wb_valid = 0; mem_busy = 0; if_busy = 0; trap_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #2;
    checks++;
    if (ctl !== 8'b0000_1111 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL reset_outputs ctl=%b pc=%b exp ctl=00001111 pc=00", ctl, pc_sel);
    end
    tick(); tick();
    rst = 0;
    #2;
    checks++;
    if (ctl !== 8'b1111_0000 || stall_cnt !== 32'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL post_reset ctl=%b stall=%0d to=%b exp ctl=11110000 stall=0 to=0", ctl, stall_cnt, timeout_err);
    end
    tick();
  endtask

  task automatic test_loaduse();
    // ld x5 in EXE, add x6,x5,x1 in ID
    idle();
    exe_valid = 1; exe_mem_read = 1; exe_rd_en = 1; exe_rd = 5;
    id_valid = 1; id_rs1_en = 1; id_rs1 = 5; id_rs2_en = 1; id_rs2 = 1;
    #2;
    checks++;
    if (ctl !== 8'b0001_0010 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL loaduse_bubble ctl=%b pc=%b exp ctl=00010010 pc=00", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    exe_valid = 0; exe_mem_read = 0; exe_rd_en = 0;
    #2;
    checks++;
    if (ctl !== 8'b1111_0000 || stall_cnt !== 32'(exp_stall)) begin
      errors++; $display("FAIL loaduse_resolve ctl=%b stall=%0d exp ctl=11110000 stall=%0d", ctl, stall_cnt, exp_stall);
    end
    tick();
    // rd=x0 never hazards; rs2-only match does
    exe_valid = 1; exe_mem_read = 1; exe_rd_en = 1; exe_rd = 0; id_rs1 = 0;
    #2;
    checks++;
    if (ctl !== 8'b1111_0000) begin
      errors++; $display("FAIL loaduse_x0 ctl=%b exp 11110000", ctl);
    end
    tick();
    exe_rd = 9; id_rs1_en = 0; id_rs1 = 9; id_rs2 = 9;
    #2;
    checks++;
    if (ctl !== 8'b0001_0010) begin
      errors++; $display("FAIL loaduse_rs2 ctl=%b exp 00010010", ctl);
    end
    exp_stall++;
    tick();
    id_rs2_en = 0;
    #2;
    checks++;
    if (ctl !== 8'b1111_0000) begin
      errors++; $display("FAIL loaduse_rs_disabled ctl=%b exp 11110000", ctl);
    end
    tick();
    idle();
  endtask

  task automatic test_multicycle();
    idle();
    exe_busy = 1; exe_redirect = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (ctl !== 8'b0000_0001 || pc_sel !== 2'b00) begin
        errors++; $display("FAIL multicycle_busy%0d ctl=%b pc=%b exp ctl=00000001 pc=00", i, ctl, pc_sel);
      end
      exp_stall++;
      tick();
    end
    exe_busy = 0;
    #2;
    checks++;
    if (ctl !== 8'b0011_1100 || pc_sel !== 2'b01) begin
      errors++; $display("FAIL multicycle_redirect ctl=%b pc=%b exp ctl=00111100 pc=01", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    idle();
    exe_fw_valid = 0;
    #2;
    checks++;
    if (ctl !== 8'b0000_0001) begin
      errors++; $display("FAIL fw_invalid ctl=%b exp 00000001", ctl);
    end
    exp_stall++;
    tick();
    idle();
    #2;
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      errors++; $display("FAIL multicycle_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_fence();
    logic [2:0] occ [3];
    occ[0] = 3'b111; occ[1] = 3'b011; occ[2] = 3'b001;
    idle();
    id_valid = 1; id_fence_i = 1; exe_valid = 1; mem_valid = 1; wb_valid = 1;
    #2;
    checks++;
    if (ctl !== 8'b0001_0010 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL fence_enter ctl=%b pc=%b exp ctl=00010010 pc=00", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    for (int i = 0; i < 3; i++) begin
      {exe_valid, mem_valid, wb_valid} = occ[i];
      #2;
      checks++;
      if (ctl !== 8'b0001_0010 || pc_sel !== 2'b00) begin
        errors++; $display("FAIL fence_drain%0d ctl=%b pc=%b exp ctl=00010010 pc=00", i, ctl, pc_sel);
      end
      exp_stall++;
      tick();
    end
    {exe_valid, mem_valid, wb_valid} = 3'b000;
    #2;
    checks++;
    if (ctl !== 8'b0011_1100 || pc_sel !== 2'b11) begin
      errors++; $display("FAIL fence_refetch ctl=%b pc=%b exp ctl=00111100 pc=11", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    idle();
    #2;
    checks++;
    if (ctl !== 8'b1111_0000 || pc_sel !== 2'b00 || stall_cnt !== 32'(exp_stall)) begin
      errors++; $display("FAIL fence_back_to_run ctl=%b pc=%b stall=%0d exp ctl=11110000 pc=00 stall=%0d", ctl, pc_sel, stall_cnt, exp_stall);
    end
    tick();
  endtask

  task automatic test_trap();
    idle();
    trap_req = 1; mem_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (ctl !== 8'b0000_0000 || pc_sel !== 2'b00) begin
        errors++; $display("FAIL trap_wait%0d ctl=%b pc=%b exp ctl=00000000 pc=00", i, ctl, pc_sel);
      end
      exp_stall++;
      tick();
    end
    trap_req = 0; mem_busy = 0;
    #2;
    checks++;
    if (ctl !== 8'b0000_1111 || pc_sel !== 2'b10) begin
      errors++; $display("FAIL trap_release ctl=%b pc=%b exp ctl=00001111 pc=10", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    #2;
    checks++;
    if (ctl !== 8'b1111_0000 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL trap_back_to_run ctl=%b pc=%b exp ctl=11110000 pc=00", ctl, pc_sel);
    end
    tick();
    // Immediate trap with no D-miss
    trap_req = 1;
    #2;
    checks++;
    if (ctl !== 8'b0000_1111 || pc_sel !== 2'b10) begin
      errors++; $display("FAIL trap_immediate ctl=%b pc=%b exp ctl=00001111 pc=10", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    idle();
  endtask

  task automatic test_drain_trap();
    idle();
    id_valid = 1; id_fence_i = 1; mem_valid = 1;
    #2;
    exp_stall++;
    tick();
    id_fence_i = 0; trap_req = 1;
    #2;
    checks++;
    if (ctl !== 8'b0000_1111 || pc_sel !== 2'b10) begin
      errors++; $display("FAIL drain_trap ctl=%b pc=%b exp ctl=00001111 pc=10", ctl, pc_sel);
    end
    exp_stall++;
    tick();
    idle();
    #2;
    checks++;
    if (ctl !== 8'b1111_0000 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL drain_trap_abandon ctl=%b pc=%b exp ctl=11110000 pc=00", ctl, pc_sel);
    end
    tick();
  endtask

  task automatic test_priority();
    idle();
    mem_busy = 1; if_busy = 1;
    exe_valid = 1; exe_mem_read = 1; exe_rd_en = 1; exe_rd = 7;
    id_valid = 1; id_rs1_en = 1; id_rs1 = 7;
    #2;
    checks++;
    if (ctl !== 8'b0000_0000) begin
      errors++; $display("FAIL prio_membusy ctl=%b exp 00000000", ctl);
    end
    exp_stall++;
    tick();
    mem_busy = 0;
    #2;
    checks++;
    if (ctl !== 8'b0001_0010) begin
      errors++; $display("FAIL prio_lu_over_ifbusy ctl=%b exp 00010010", ctl);
    end
    exp_stall++;
    tick();
    exe_valid = 0;
    #2;
    checks++;
    if (ctl !== 8'b0011_0100) begin
      errors++; $display("FAIL prio_ifbusy ctl=%b exp 00110100", ctl);
    end
    exp_stall++;
    tick();
    idle();
    #2;
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      errors++; $display("FAIL prio_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_timeout();
    idle();
    id_valid = 1; id_fence_i = 1; exe_valid = 1; mem_valid = 1;
    #2;
    tick();
    mem_busy = 1;
    for (int i = 0; i < 64; i++) begin
      #2;
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++; $display("FAIL timeout_early cycle=%0d got=%b exp=0", i, timeout_err);
      end
      tick();
    end
    #2;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_rise got=%b exp=1", timeout_err);
    end
    for (int i = 0; i < 3; i++) tick();
    #2;
    checks++;
    if (timeout_err !== 1'b1 || ctl !== 8'b0001_0010) begin
      errors++; $display("FAIL timeout_sticky to=%b ctl=%b exp to=1 ctl=00010010", timeout_err, ctl);
    end
    tick();
    // Reset mid-DRAIN: back to RUN, no refetch pulse
    rst = 1; idle();
    #2;
    checks++;
    if (ctl !== 8'b0000_1111 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL timeout_rst_cycle ctl=%b pc=%b exp ctl=00001111 pc=00", ctl, pc_sel);
    end
    tick();
    rst = 0;
    #2;
    checks++;
    if (ctl !== 8'b1111_0000 || pc_sel !== 2'b00 || timeout_err !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL timeout_after_rst ctl=%b pc=%b to=%b stall=%0d exp ctl=11110000 pc=00 to=0 stall=0", ctl, pc_sel, timeout_err, stall_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_multicycle();
    test_fence();
    test_trap();
    test_drain_trap();
    test_priority();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
